// File: rtl/sram_arbiter_if.sv
// Signal bundle between sram_arbiter, its two requesters (CPU, VGA) and the SRAM pins.
// slave = arbiter side; master = requesters plus the SRAM data-in path.
interface sram_arbiter_if #(
    parameter int unsigned ADDR_W = 22
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [1:0]        cpu_be;
    logic [15:0]       cpu_wdata;
    logic [15:0]       cpu_rdata;
    logic              cpu_ack;

    logic              vga_re;
    logic [22:0]       vga_addr;
    logic [15:0]       vga_data;
    logic              vga_success;

    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_dq_i;
    logic [15:0]       sram_dq_o;
    logic              sram_dq_oe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [1:0]        sram_be_n;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  vga_re, vga_addr,
        output vga_data, vga_success,
        output sram_addr, sram_dq_o, sram_dq_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        input  sram_dq_i
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output vga_re, vga_addr,
        input  vga_data, vga_success,
        input  sram_addr, sram_dq_o, sram_dq_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        output sram_dq_i
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one async 16-bit SRAM between the CPU data port and the VGA loader.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed VGA-over-CPU priority.
module sram_arbiter #(
    parameter int unsigned ADDR_W   = 22,
    parameter int unsigned WAIT_CYC = 2
) (
    input logic           clk,
    input logic           rst,
    sram_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WAIT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_VGA_OUT,
        S_TURN
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             is_vga, is_vga_nx;
    logic             grant_vga_c, grant_cpu_c;
    logic             vga_lsb_unused;

    // Registered outputs and their next values
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]       sram_dq_o_q, sram_dq_o_d;
    logic              sram_dq_oe_q, sram_dq_oe_d;
    logic              sram_ce_n_q, sram_ce_n_d;
    logic              sram_oe_n_q, sram_oe_n_d;
    logic              sram_we_n_q, sram_we_n_d;
    logic [1:0]        sram_be_n_q, sram_be_n_d;
    logic [15:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic [15:0]       vga_data_q, vga_data_d;
    logic              vga_success_q, vga_success_d;

    // Byte address from the VGA side; bit 0 has no meaning for a 16-bit word
    assign vga_lsb_unused = bus.vga_addr[0];

`ifdef SRAM_ARB_RR_EN
    logic last_grant;  // 0 = CPU, 1 = VGA

    assign grant_vga_c = bus.vga_re && (!bus.cpu_req || !last_grant);

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b0;
        end else if (state == S_IDLE && (grant_vga_c || grant_cpu_c)) begin
            last_grant <= grant_vga_c;
        end
    end
`else
    assign grant_vga_c = bus.vga_re;
`endif

    assign grant_cpu_c = bus.cpu_req && !grant_vga_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_vga <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            is_vga <= is_vga_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        is_vga_nx = is_vga;
        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (grant_vga_c) begin
                    is_vga_nx = 1'b1;
                    state_nx  = S_RD;
                end else if (grant_cpu_c) begin
                    is_vga_nx = 1'b0;
                    state_nx  = bus.cpu_we ? S_WR_SETUP : S_RD;
                end
            end
            S_RD: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = is_vga ? S_VGA_OUT : S_TURN;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_VGA_OUT: begin
                if (cnt == CNT_ONE) begin
                    cnt_nx   = '0;
                    state_nx = S_TURN;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_WR_SETUP: begin
                cnt_nx   = '0;
                state_nx = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = S_WR_HOLD;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            S_WR_HOLD: state_nx = S_TURN;
            S_TURN:    state_nx = S_IDLE;
            default: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

    // Output logic: values for the state being entered, registered on the same edge
    always_comb begin
        sram_addr_d   = sram_addr_q;
        sram_dq_o_d   = sram_dq_o_q;
        sram_dq_oe_d  = 1'b0;
        sram_ce_n_d   = 1'b1;
        sram_oe_n_d   = 1'b1;
        sram_we_n_d   = 1'b1;
        sram_be_n_d   = 2'b11;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_ack_d     = 1'b0;
        vga_data_d    = vga_data_q;
        vga_success_d = 1'b0;

        if (state == S_IDLE) begin
            if (grant_vga_c) begin
                sram_addr_d = bus.vga_addr[ADDR_W:1];
            end else if (grant_cpu_c) begin
                sram_addr_d = bus.cpu_addr;
            end
        end

        if (state == S_RD && cnt == CNT_LAST) begin
            if (is_vga) begin
                vga_data_d = bus.sram_dq_i;
            end else begin
                cpu_rdata_d = bus.sram_dq_i;
                cpu_ack_d   = 1'b1;
            end
        end

        case (state_nx)
            S_RD: begin
                sram_ce_n_d = 1'b0;
                sram_oe_n_d = 1'b0;
                sram_be_n_d = is_vga_nx ? 2'b00 : ~bus.cpu_be;
            end
            S_WR_SETUP: begin
                sram_ce_n_d  = 1'b0;
                sram_dq_oe_d = 1'b1;
                sram_dq_o_d  = bus.cpu_wdata;
                sram_be_n_d  = ~bus.cpu_be;
            end
            S_WR_PULSE: begin
                sram_ce_n_d  = 1'b0;
                sram_dq_oe_d = 1'b1;
                sram_be_n_d  = ~bus.cpu_be;
                // No byte lanes enabled: run the sequence without a write pulse
                sram_we_n_d  = (bus.cpu_be == 2'b00);
            end
            S_WR_HOLD: begin
                sram_ce_n_d  = 1'b0;
                sram_dq_oe_d = 1'b1;
                sram_be_n_d  = ~bus.cpu_be;
                cpu_ack_d    = 1'b1;
            end
            S_VGA_OUT: vga_success_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            sram_addr_q   <= '0;
            sram_dq_o_q   <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_ce_n_q   <= 1'b1;
            sram_oe_n_q   <= 1'b1;
            sram_we_n_q   <= 1'b1;
            sram_be_n_q   <= 2'b11;
            cpu_rdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            vga_data_q    <= '0;
            vga_success_q <= 1'b0;
        end else begin
            sram_addr_q   <= sram_addr_d;
            sram_dq_o_q   <= sram_dq_o_d;
            sram_dq_oe_q  <= sram_dq_oe_d;
            sram_ce_n_q   <= sram_ce_n_d;
            sram_oe_n_q   <= sram_oe_n_d;
            sram_we_n_q   <= sram_we_n_d;
            sram_be_n_q   <= sram_be_n_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
            vga_data_q    <= vga_data_d;
            vga_success_q <= vga_success_d;
        end
    end

    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_o   = sram_dq_o_q;
    assign bus.sram_dq_oe  = sram_dq_oe_q;
    assign bus.sram_ce_n   = sram_ce_n_q;
    assign bus.sram_oe_n   = sram_oe_n_q;
    assign bus.sram_we_n   = sram_we_n_q;
    assign bus.sram_be_n   = sram_be_n_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.vga_data    = vga_data_q;
    assign bus.vga_success = vga_success_q;

endmodule
